car_velocity_integrator: RTL

Downstream consumer of the 2-bit keyboard acceleration command (10 = forward, 01 = reverse, 00 = none). Converts the command into a saturating signed speed and a wrapping position on a fixed physics tick. With no command held, speed coasts toward zero. Feeds the display/renderer stage, which reads speed, position and motion state.

---
 rtl/car_velocity_integrator.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/car_velocity_integrator.sv
// car_velocity_integrator: turns the 2-bit keyboard acceleration command into
// a saturating signed speed and a wrapping position, updated once per physics
// tick. Speed coasts toward zero when no command is held.
module car_velocity_integrator #(
  parameter int TICK_DIV   = 2500000,
  parameter int SPEED_W    = 8,
  parameter int MAX_SPEED  = 64,
  parameter int ACCEL_STEP = 2,
  parameter int DECAY_DIV  = 3,
  parameter int POS_W      = 16
) (
  input  logic                      CLOCK_50,
  input  logic                      resetn,
  input  logic                      enable,
  input  logic [1:0]                accel,
  output logic signed [SPEED_W-1:0] speed,
  output logic [POS_W-1:0]          position,
  output logic                      tick,
  output logic [1:0]                motion
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int DEC_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;

  localparam logic [CNT_W-1:0]        LP_TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [DEC_W-1:0]        LP_DEC_LAST  = DEC_W'(DECAY_DIV - 1);
  localparam logic signed [SPEED_W:0] LP_MAX       = (SPEED_W + 1)'(MAX_SPEED);
  localparam logic signed [SPEED_W:0] LP_MIN       = -LP_MAX;
  localparam logic signed [SPEED_W:0] LP_STEP      = (SPEED_W + 1)'(ACCEL_STEP);
  localparam logic signed [SPEED_W:0] LP_ONE       = (SPEED_W + 1)'(1);

  // Elaboration-time parameter sanity checks
  if (TICK_DIV < 2) begin : g_bad_tick_div
    $error("TICK_DIV must be >= 2");
  end
  if (DECAY_DIV < 1) begin : g_bad_decay_div
    $error("DECAY_DIV must be >= 1");
  end
  if (MAX_SPEED + ACCEL_STEP >= 2 ** (SPEED_W - 1)) begin : g_bad_speed_range
    $error("MAX_SPEED + ACCEL_STEP must be < 2^(SPEED_W-1)");
  end

  typedef enum logic [1:0] {
    ST_STOPPED = 2'b00,
    ST_FORWARD = 2'b01,
    ST_REVERSE = 2'b10
  } motion_t;

  logic [CNT_W-1:0]          r_tick_cnt;
  logic signed [SPEED_W-1:0] r_speed;
  logic [POS_W-1:0]          r_position;
  logic [DEC_W-1:0]          r_decay_cnt;
  logic                      r_tick;
  motion_t                   r_motion;

  logic                      w_update;
  logic signed [SPEED_W:0]   w_speed_wide;
  logic signed [SPEED_W:0]   w_sum_fwd;
  logic signed [SPEED_W:0]   w_sum_rev;
  logic signed [SPEED_W:0]   w_speed_next_wide;
  logic signed [SPEED_W-1:0] w_speed_next;
  logic [DEC_W-1:0]          w_decay_next;
  logic [POS_W+SPEED_W-1:0]  w_speed_sext;
  logic [POS_W-1:0]          w_pos_next;
  motion_t                   w_motion_next;

  assign w_update = enable && (r_tick_cnt == LP_TICK_LAST);

  // Next speed and decay count, computed one bit wider so clamping sees no wrap
  always_comb begin
    w_speed_wide      = {r_speed[SPEED_W-1], r_speed};
    w_sum_fwd         = w_speed_wide + LP_STEP;
    w_sum_rev         = w_speed_wide - LP_STEP;
    w_speed_next_wide = w_speed_wide;
    w_decay_next      = r_decay_cnt;
    case (accel)
      2'b10: begin
        w_speed_next_wide = (w_sum_fwd > LP_MAX) ? LP_MAX : w_sum_fwd;
        w_decay_next      = '0;
      end
      2'b01: begin
        w_speed_next_wide = (w_sum_rev < LP_MIN) ? LP_MIN : w_sum_rev;
        w_decay_next      = '0;
      end
      default: begin
        if (r_speed == '0) begin
          w_decay_next = '0;
        end else if (r_decay_cnt == LP_DEC_LAST) begin
          w_speed_next_wide = r_speed[SPEED_W-1] ? (w_speed_wide + LP_ONE)
                                                 : (w_speed_wide - LP_ONE);
          w_decay_next      = '0;
        end else begin
          w_decay_next = r_decay_cnt + 1'b1;
        end
      end
    endcase
    w_speed_next = w_speed_next_wide[SPEED_W-1:0];
  end

  // Explicit Euler: position advances by the speed held before this update
  always_comb begin
    w_speed_sext = {{POS_W{r_speed[SPEED_W-1]}}, r_speed};
    w_pos_next   = r_position + w_speed_sext[POS_W-1:0];
  end

  // Tick counter, speed, position and decay registers
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      r_tick_cnt  <= '0;
      r_speed     <= '0;
      r_position  <= '0;
      r_decay_cnt <= '0;
      r_tick      <= 1'b0;
    end else begin
      r_tick <= w_update;
      if (enable) begin
        r_tick_cnt <= w_update ? '0 : (r_tick_cnt + 1'b1);
      end
      if (w_update) begin
        r_speed     <= w_speed_next;
        r_position  <= w_pos_next;
        r_decay_cnt <= w_decay_next;
      end
    end
  end

  // Motion state register
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      r_motion <= ST_STOPPED;
    end else begin
      r_motion <= w_motion_next;
    end
  end

  // Motion next state follows the sign of the speed being committed
  always_comb begin
    w_motion_next = r_motion;
    if (w_update) begin
      if (w_speed_next == '0) begin
        w_motion_next = ST_STOPPED;
      end else if (w_speed_next[SPEED_W-1]) begin
        w_motion_next = ST_REVERSE;
      end else begin
        w_motion_next = ST_FORWARD;
      end
    end
  end

  // Outputs
  always_comb begin
    speed    = r_speed;
    position = r_position;
    tick     = r_tick;
    motion   = r_motion;
  end

endmodule
